// File: rtl/pla_fsm_engine_pkg.sv
// Shared constants, entry layout and sizing helper for the PLA-style FSM engine.
package pla_fsm_engine_pkg;

  localparam int DEF_NUM_STATES = 7;
  localparam int DEF_IN_W       = 1;
  localparam int DEF_OUT_W      = 2;
  localparam int DEF_SW         = $clog2(DEF_NUM_STATES);
  localparam int DEF_DEPTH      = DEF_NUM_STATES * (2 ** DEF_IN_W);
  localparam int DEF_AW         = $clog2(DEF_DEPTH);
  localparam int DEF_DW         = DEF_SW + DEF_OUT_W;

  // State index loaded by reset, restart, upset recovery and illegal next.
  localparam int RESET_IDX = 0;

  typedef struct packed {
    logic [DEF_SW-1:0]    next_idx;
    logic [DEF_OUT_W-1:0] z;
  } pla_entry_t;

  function automatic int pla_depth(input int num_states, input int in_w);
    return num_states * (1 << in_w);
  endfunction

endpackage

// File: rtl/pla_fsm_engine_if.sv
// Step/config/status bundle between the engine and its driver.
interface pla_fsm_engine_if
  import pla_fsm_engine_pkg::*;
#(
    parameter int NUM_STATES = DEF_NUM_STATES,
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W
) ();

    localparam int SW = $clog2(NUM_STATES);
    localparam int AW = $clog2(pla_depth(NUM_STATES, IN_W));
    localparam int DW = SW + OUT_W;

    // Handshake: in_valid has no backpressure; every cycle with in_valid=1
    // (and no restart/upset) is a step whose result appears with a one-cycle
    // out_valid pulse on the following cycle.
    logic                  in_valid;
    logic [IN_W-1:0]       x;
    logic                  restart;
    logic                  cfg_we;
    logic [AW-1:0]         cfg_addr;
    logic [DW-1:0]         cfg_data;
    logic                  err_clr;
    logic [NUM_STATES-1:0] state_oh;
    logic [OUT_W-1:0]      z;
    logic                  out_valid;
    logic                  err;

    modport master (
        output in_valid, x, restart, cfg_we, cfg_addr, cfg_data, err_clr,
        input  state_oh, z, out_valid, err
    );

    modport slave (
        input  in_valid, x, restart, cfg_we, cfg_addr, cfg_data, err_clr,
        output state_oh, z, out_valid, err
    );

endinterface

// File: rtl/pla_fsm_engine_table.sv
// Transition table: DEPTH x DW register file, one write port, one async read port.
module pla_fsm_table #(
    parameter int DEPTH = 14,
    parameter int AW    = 4,
    parameter int DW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is invisible.
    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/pla_fsm_engine.sv
// Table-driven one-hot FSM: each step looks up {next_idx, z} by {state, x}.
module pla_fsm_engine
  import pla_fsm_engine_pkg::*;
#(
    parameter int NUM_STATES = DEF_NUM_STATES,
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W
) (
    input logic             clk,
    input logic             rst_n,
    pla_fsm_engine_if.slave bus
);

    localparam int SW    = $clog2(NUM_STATES);
    localparam int DEPTH = pla_depth(NUM_STATES, IN_W);
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = SW + OUT_W;

    localparam logic [NUM_STATES-1:0] RESET_OH = NUM_STATES'(1) << RESET_IDX;

    logic [NUM_STATES-1:0] state_q;
    logic [OUT_W-1:0]      z_q;
    logic                  out_valid_q;
    logic                  err_q;

    logic [SW-1:0]         cur_idx;
    logic                  onehot_ok;
    logic [AW-1:0]         rd_addr;
    logic [DW-1:0]         rd_data;
    logic [SW-1:0]         rd_next;
    logic [OUT_W-1:0]      rd_z;
    logic                  next_bad;
    logic                  step;
    logic                  err_set;

    // OR-of-bits encoder: no priority, only meaningful when onehot_ok.
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (state_q[i]) begin
                cur_idx = cur_idx | SW'(i);
            end
        end
    end

    assign onehot_ok = (state_q != '0) &&
                       ((state_q & (state_q - NUM_STATES'(1))) == '0);

    assign rd_addr  = AW'({cur_idx, bus.x});
    assign rd_next  = rd_data[DW-1:OUT_W];
    assign rd_z     = rd_data[OUT_W-1:0];
    assign next_bad = (32'(rd_next) >= NUM_STATES);
    assign step     = onehot_ok && !bus.restart && bus.in_valid;
    assign err_set  = !onehot_ok || (step && next_bad);

    pla_fsm_table #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.cfg_we),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_OH;
            z_q         <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (!onehot_ok || bus.restart) begin
                state_q <= RESET_OH;
                z_q     <= '0;
            end else if (bus.in_valid) begin
                state_q     <= next_bad ? RESET_OH : (NUM_STATES'(1) << rd_next);
                z_q         <= rd_z;
                out_valid_q <= 1'b1;
            end
            // A newly detected error beats a same-cycle clear.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.state_oh  = state_q;
    assign bus.z         = z_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_pla_fsm_engine.sv
// Bench for pla_fsm_engine: directed vector table, corner sequences, random run vs model.
module tb_pla_fsm_engine;
  import pla_fsm_engine_pkg::*;

  localparam int NS = 7;
  localparam int IW = 1;
  localparam int OW = 2;
  localparam int W  = NS + OW + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pla_fsm_engine_if #(.NUM_STATES(NS), .IN_W(IW), .OUT_W(OW)) bus ();

  pla_fsm_engine #(.NUM_STATES(NS), .IN_W(IW), .OUT_W(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [4:0] data;
    logic       iv;
    logic       x;
    logic       rs;
    logic       ec;
    logic [6:0] e_st;
    logic [1:0] e_z;
    logic       e_ov;
    logic       e_err;
  } vec_t;

  vec_t       vecs [19];
  logic [W-1:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  logic [4:0] m_tbl [14];
  int         m_st;
  logic [1:0] m_z;
  logic       m_err;

  task automatic drive(input logic we, input logic [3:0] addr, input logic [4:0] data,
                       input logic iv, input logic x, input logic rs, input logic ec);
    bus.cfg_we   = we;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    bus.in_valid = iv;
    bus.x        = x;
    bus.restart  = rs;
    bus.err_clr  = ec;
  endtask

  task automatic check_out(input string name);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    exp = exp_q.pop_front();
    got = {bus.state_oh, bus.z, bus.out_valid, bus.err};
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%b z=%b ov=%b err=%b, want st=%b z=%b ov=%b err=%b",
               name, got[10:4], got[3:2], got[1], got[0],
               exp[10:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic tick_check(input string name);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  // Index-based reference: read old entry, then apply the write.
  task automatic model_step(input logic we, input logic [3:0] addr, input logic [4:0] data,
                            input logic iv, input logic x, input logic rs, input logic ec,
                            output logic [W-1:0] e);
    logic       ov;
    logic       set;
    logic [4:0] ent;
    ov  = 1'b0;
    set = 1'b0;
    if (rs) begin
      m_st = 0;
      m_z  = 2'b00;
    end else if (iv) begin
      ent = m_tbl[m_st * 2 + int'(x)];
      ov  = 1'b1;
      m_z = ent[1:0];
      if (ent[4:2] >= 3'd7) begin
        m_st = 0;
        set  = 1'b1;
      end else begin
        m_st = int'(ent[4:2]);
      end
    end
    if (set) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    if (we && addr < 4'd14) m_tbl[addr] = data;
    e = {7'(1) << m_st, m_z, ov, m_err};
  endtask

  initial begin
    logic [W-1:0] e;
    logic         r_we, r_iv, r_x, r_rs, r_ec;
    logic [3:0]   r_addr;
    logic [4:0]   r_data;

    //          we addr  data      iv x  rs ec  state       z      ov err
    vecs[0]  = '{0, 4'd0,  5'b00000, 0, 0, 0, 0, 7'b0000001, 2'b00, 0, 0};
    vecs[1]  = '{0, 4'd0,  5'b00000, 1, 0, 0, 0, 7'b0000001, 2'b00, 1, 0};
    vecs[2]  = '{1, 4'd0,  5'b10010, 0, 0, 0, 0, 7'b0000001, 2'b00, 0, 0};
    vecs[3]  = '{0, 4'd0,  5'b00000, 1, 0, 0, 0, 7'b0010000, 2'b10, 1, 0};
    vecs[4]  = '{0, 4'd0,  5'b00000, 0, 1, 0, 0, 7'b0010000, 2'b10, 0, 0};
    vecs[5]  = '{1, 4'd1,  5'b11101, 0, 0, 0, 0, 7'b0010000, 2'b10, 0, 0};
    vecs[6]  = '{0, 4'd0,  5'b00000, 0, 0, 1, 0, 7'b0000001, 2'b00, 0, 0};
    vecs[7]  = '{0, 4'd0,  5'b00000, 1, 1, 0, 0, 7'b0000001, 2'b01, 1, 1};
    vecs[8]  = '{0, 4'd0,  5'b00000, 0, 0, 0, 1, 7'b0000001, 2'b01, 0, 0};
    vecs[9]  = '{0, 4'd0,  5'b00000, 1, 0, 0, 0, 7'b0010000, 2'b10, 1, 0};
    vecs[10] = '{0, 4'd0,  5'b00000, 1, 0, 1, 0, 7'b0000001, 2'b00, 0, 0};
    vecs[11] = '{0, 4'd0,  5'b00000, 1, 0, 0, 0, 7'b0010000, 2'b10, 1, 0};
    vecs[12] = '{1, 4'd8,  5'b01011, 1, 0, 0, 0, 7'b0000001, 2'b00, 1, 0};
    vecs[13] = '{0, 4'd0,  5'b00000, 1, 0, 0, 0, 7'b0010000, 2'b10, 1, 0};
    vecs[14] = '{0, 4'd0,  5'b00000, 1, 0, 0, 0, 7'b0000100, 2'b11, 1, 0};
    vecs[15] = '{1, 4'd15, 5'b00111, 0, 0, 0, 0, 7'b0000100, 2'b11, 0, 0};
    vecs[16] = '{0, 4'd0,  5'b00000, 0, 0, 1, 0, 7'b0000001, 2'b00, 0, 0};
    vecs[17] = '{0, 4'd0,  5'b00000, 1, 1, 0, 1, 7'b0000001, 2'b01, 1, 1};
    vecs[18] = '{0, 4'd0,  5'b00000, 0, 0, 0, 1, 7'b0000001, 2'b01, 0, 0};

    drive(0, 4'd0, 5'd0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back({7'b0000001, 2'b00, 1'b0, 1'b0});
    check_out("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].iv, vecs[i].x,
            vecs[i].rs, vecs[i].ec);
      exp_q.push_back({vecs[i].e_st, vecs[i].e_z, vecs[i].e_ov, vecs[i].e_err});
      tick_check($sformatf("vec%0d", i));
    end

    // Upset: non-one-hot state is scrubbed on the next edge despite in_valid.
    drive(0, 4'd0, 5'd0, 1, 0, 0, 0);
    force dut.state_q = 7'b0000110;
    #1 release dut.state_q;
    exp_q.push_back({7'b0000001, 2'b00, 1'b0, 1'b1});
    tick_check("upset");
    drive(0, 4'd0, 5'd0, 0, 0, 0, 1);
    exp_q.push_back({7'b0000001, 2'b00, 1'b0, 1'b0});
    tick_check("upset_clr");

    // Reset in the middle of a step cycle: step dropped, table cleared.
    drive(0, 4'd0, 5'd0, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back({7'b0000001, 2'b00, 1'b0, 1'b0});
    check_out("rst_async");
    drive(0, 4'd0, 5'd0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back({7'b0000001, 2'b00, 1'b0, 1'b0});
    tick_check("rst_release");
    drive(0, 4'd0, 5'd0, 1, 0, 0, 0);
    exp_q.push_back({7'b0000001, 2'b00, 1'b1, 1'b0});
    tick_check("tbl_cleared");

    m_st  = 0;
    m_z   = 2'b00;
    m_err = 1'b0;
    for (int i = 0; i < 14; i++) m_tbl[i] = 5'd0;

    for (int n = 0; n < 400; n++) begin
      r_we   = ($urandom_range(0, 2) == 0);
      r_addr = 4'($urandom_range(0, 15));
      r_data = 5'($urandom_range(0, 31));
      r_iv   = ($urandom_range(0, 3) != 0);
      r_x    = 1'($urandom_range(0, 1));
      r_rs   = ($urandom_range(0, 15) == 0);
      r_ec   = ($urandom_range(0, 7) == 0);
      drive(r_we, r_addr, r_data, r_iv, r_x, r_rs, r_ec);
      model_step(r_we, r_addr, r_data, r_iv, r_x, r_rs, r_ec, e);
      exp_q.push_back(e);
      tick_check($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pla_fsm_engine.md
PLA_FSM_ENGINE -- requirements
Module: pla_fsm_engine

Interface
REQ-001 Parameter NUM_STATES, default 7: number of states, one-hot encoded, minimum 2.
REQ-002 Parameter IN_W, default 1: primary input width.
REQ-003 Parameter OUT_W, default 2: primary output width.
REQ-004 Derived constants SHALL be SW = clog2(NUM_STATES), DEPTH = NUM_STATES*2^IN_W, AW = clog2(DEPTH), DW = SW+OUT_W.
REQ-005 The block has one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  step request, x sampled this cycle.
REQ-009 x  in  IN_W  primary input.
REQ-010 restart  in  1  synchronous return to state 0.
REQ-011 cfg_we  in  1  transition-table write strobe.
REQ-012 cfg_addr  in  AW  table index = state_idx*2^IN_W + x.
REQ-013 cfg_data  in  DW  {next_idx[SW-1:0], z[OUT_W-1:0]}.
REQ-014 err_clr  in  1  clears sticky err.
REQ-015 state_oh  out  NUM_STATES  registered one-hot current state.
REQ-016 z  out  OUT_W  registered output of last step.
REQ-017 out_valid  out  1  one-cycle pulse, step result on z/state_oh.
REQ-018 err  out  1  sticky illegal-state/illegal-next flag.

Function
REQ-019 Step: when in_valid=1 and restart=0, the block SHALL read entry [idx(state_oh)*2^IN_W + x] and, on the same edge, load state_oh with onehot(next_idx), z with entry z, out_valid=1; latency one cycle.
REQ-020 out_valid SHALL be 0 in any cycle following a non-step cycle; back-to-back steps SHALL produce back-to-back pulses with no bubbles.
REQ-021 With in_valid=0, state_oh and z SHALL hold.
REQ-022 restart=1 SHALL load state_oh=onehot(0), z=0, out_valid=0; restart has priority over in_valid.
REQ-023 A table write SHALL take effect on the clock edge; a step reading the entry being written in the same cycle SHALL use the old contents.
REQ-024 cfg_we with cfg_addr >= DEPTH SHALL be ignored.
REQ-025 Entry next_idx >= NUM_STATES on a step SHALL load state_oh=onehot(0), still load entry z, pulse out_valid, and set err.
REQ-026 state_oh not exactly one-hot (upset) SHALL, on the next edge, force state_oh=onehot(0), z=0, out_valid=0, set err, regardless of in_valid.
REQ-027 err SHALL clear on err_clr=1 unless a new error is detected that cycle; set wins over clear.
REQ-028 Index encode of state_oh SHALL be a priority-free one-hot-to-binary encoder, valid only when REQ-026 is not triggered.

Reset
REQ-029 rst_n=0 SHALL immediately set state_oh=onehot(0), z=0, out_valid=0, err=0, every table entry = 0 (next_idx=0, z=0).
REQ-030 Reset asserted mid-step SHALL discard the step; no out_valid pulse follows deassertion.
REQ-031 Deassertion SHALL be synchronised by the integrator; the block reacts to no input in the reset-release cycle differently from any other cycle.

Structure
REQ-032 A shared package SHALL hold the entry struct {next_idx, z}, the clog2-derived widths, and the reset-state constant (state index 0).
REQ-033 One sub-module, pla_fsm_table (DEPTH x DW register file, one write port, one async read port), is natural; next-state/output/error logic stays in the top.

Verification (defaults 7/1/2, DW=5)
REQ-034 Reset: rst_n=0 -> state_oh=7'b0000001, z=2'b00, out_valid=0, err=0.
REQ-035 Write addr 0 data {3'd4,2'b10}; in_valid=1, x=0 -> next cycle state_oh=7'b0010000, z=2'b10, out_valid=1; following idle cycle out_valid=0.
REQ-036 Write addr 1 data {3'd7,2'b01}; step x=1 from state 0 -> state_oh=7'b0000001, z=2'b01, err=1; err_clr=1 -> err=0.
REQ-037 restart=1 and in_valid=1 same cycle from state 4 -> state_oh=7'b0000001, z=0, out_valid=0.
REQ-038 Write addr 8 data {3'd2,2'b11} while stepping state 4, x=0 -> old entry used; repeat step -> state_oh=7'b0000100, z=2'b11.
REQ-039 Force state_oh=7'b0000110 -> next edge state_oh=7'b0000001, err=1, out_valid=0.
